// File: rtl/l2pa_dispatcher_pkg.sv
// ============================================================================
// Module      : l2pa_dispatcher_pkg
// Description : Shared memShare configuration for the L2PA dispatcher.
//               Holds the default geometry, the instance-id width derivation
//               and the FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package l2pa_dispatcher_pkg;

    localparam int DEF_SHIFT_LENGTH           = 5;
    localparam int DEF_QUAN_SIZE              = 3;
    localparam int DEF_MAX_MEMSHARE_INSTANCES = 3;

    // The instance id needs at least one bit, even for a single instance.
    function automatic int inst_id_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    typedef enum logic {
        IDLE     = 1'b0,
        DISPATCH = 1'b1
    } state_e;

endpackage

`default_nettype wire

// File: rtl/l2pa_dispatch_sel.sv
// ============================================================================
// Module      : l2pa_dispatch_sel
// Description : Combinational lowest-set-bit priority encoder over the
//               pending-instance vector. Returns the index, a one-hot grant
//               and a flag that only one instance is left.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module l2pa_dispatch_sel #(
    parameter int N = 3,
    parameter int W = 2
) (
    input  logic [N-1:0] pending_i,
    output logic [W-1:0] sel_o,
    output logic [N-1:0] grant_o,
    output logic         is_last_o
);

    // Scan from the top down so the lowest set bit is the one that sticks.
    always_comb begin
        sel_o   = '0;
        grant_o = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (pending_i[k]) begin
                sel_o      = W'(k);
                grant_o    = '0;
                grant_o[k] = 1'b1;
            end
        end
    end

    // Exactly one bit set: nonzero and clearing the lowest bit leaves zero.
    always_comb begin
        is_last_o = (pending_i != '0) && ((pending_i & (pending_i - N'(1))) == '0);
    end

endmodule

`default_nettype wire

// File: rtl/l2pa_dispatcher.sv
// ============================================================================
// Module      : l2pa_dispatcher
// Description : Level-2 page-alignment dispatcher. Accepts one aligned page
//               plus per-instance lane masks and emits it as a sequence of
//               memShare allocation beats, one per non-empty instance, with
//               lanes outside the instance mask forced to zero.
// Options     : L2PA_DISPATCH_ZERO_FILTER_EN - AND each mask with the per-lane
//               nonzero detect of the incoming page at accept time.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module l2pa_dispatcher
    import l2pa_dispatcher_pkg::*;
#(
    parameter  int SHIFT_LENGTH           = DEF_SHIFT_LENGTH,
    parameter  int QUAN_SIZE              = DEF_QUAN_SIZE,
    parameter  int MAX_MEMSHARE_INSTANCES = DEF_MAX_MEMSHARE_INSTANCES,
    localparam int INST_ID_W              = inst_id_width(MAX_MEMSHARE_INSTANCES)
) (
    input  logic                                     sys_clk,
    input  logic                                     rst,
    input  logic                                     flush_i,
    input  logic                                     in_valid_i,
    output logic                                     in_ready_o,
    input  logic [QUAN_SIZE*SHIFT_LENGTH-1:0]        page_i,
    input  logic [MAX_MEMSHARE_INSTANCES*SHIFT_LENGTH-1:0] inst_mask_i,
    output logic                                     out_valid_o,
    input  logic                                     out_ready_i,
    output logic [QUAN_SIZE*SHIFT_LENGTH-1:0]        out_page_o,
    output logic [SHIFT_LENGTH-1:0]                  out_lane_en_o,
    output logic [INST_ID_W-1:0]                     out_inst_id_o,
    output logic                                     out_last_o,
    output logic                                     empty_drop_o
);

    localparam int PW = QUAN_SIZE * SHIFT_LENGTH;
    localparam int MW = MAX_MEMSHARE_INSTANCES * SHIFT_LENGTH;

    state_e                              state_q, state_d;
    logic [PW-1:0]                       page_q, page_d;
    logic [MW-1:0]                       mask_q, mask_d;
    logic [MAX_MEMSHARE_INSTANCES-1:0]   pending_q, pending_d;
    logic                                empty_drop_q, empty_drop_d;
    logic                                ready_en_q;

    logic [MW-1:0]                       mask_in;
    logic [MAX_MEMSHARE_INSTANCES-1:0]   pending_in;
    logic [INST_ID_W-1:0]                sel;
    logic [MAX_MEMSHARE_INSTANCES-1:0]   grant;
    logic                                is_last;
    logic [SHIFT_LENGTH-1:0]             lane_en;
    logic                                accept;

`ifdef L2PA_DISPATCH_ZERO_FILTER_EN
    logic [SHIFT_LENGTH-1:0]             lane_nz;

    // A lane is nonzero if any of its bit slices is set.
    always_comb begin
        lane_nz = '0;
        for (int l = 0; l < SHIFT_LENGTH; l++) begin
            for (int b = 0; b < QUAN_SIZE; b++) begin
                lane_nz[l] = lane_nz[l] | page_i[b*SHIFT_LENGTH + l];
            end
        end
    end

    // Drop lanes carrying zero messages from every instance mask.
    always_comb begin
        mask_in = '0;
        for (int k = 0; k < MAX_MEMSHARE_INSTANCES; k++) begin
            mask_in[k*SHIFT_LENGTH +: SHIFT_LENGTH] =
                inst_mask_i[k*SHIFT_LENGTH +: SHIFT_LENGTH] & lane_nz;
        end
    end
`else
    // Masks are taken verbatim; zero lanes are still emitted.
    always_comb begin
        mask_in = inst_mask_i;
    end
`endif

    // An instance is pending when its (possibly filtered) mask is non-empty.
    always_comb begin
        pending_in = '0;
        for (int k = 0; k < MAX_MEMSHARE_INSTANCES; k++) begin
            pending_in[k] = |mask_in[k*SHIFT_LENGTH +: SHIFT_LENGTH];
        end
    end

    l2pa_dispatch_sel #(
        .N (MAX_MEMSHARE_INSTANCES),
        .W (INST_ID_W)
    ) u_sel (
        .pending_i (pending_q),
        .sel_o     (sel),
        .grant_o   (grant),
        .is_last_o (is_last)
    );

    // Select the lane mask of the granted instance (zero when nothing pends).
    always_comb begin
        lane_en = '0;
        for (int k = 0; k < MAX_MEMSHARE_INSTANCES; k++) begin
            if (grant[k]) begin
                lane_en = mask_q[k*SHIFT_LENGTH +: SHIFT_LENGTH];
            end
        end
    end

    // Beat outputs come straight from registered state, so they are stable
    // for as long as the port stalls.
    always_comb begin
        out_valid_o   = (state_q == DISPATCH);
        out_lane_en_o = lane_en;
        out_inst_id_o = sel;
        out_last_o    = (state_q == DISPATCH) && is_last;
        empty_drop_o  = empty_drop_q;
        in_ready_o    = (state_q == IDLE) && ready_en_q;
        out_page_o    = '0;
        for (int b = 0; b < QUAN_SIZE; b++) begin
            for (int l = 0; l < SHIFT_LENGTH; l++) begin
                out_page_o[b*SHIFT_LENGTH + l] = page_q[b*SHIFT_LENGTH + l] & lane_en[l];
            end
        end
    end

    assign accept = in_valid_i && in_ready_o;

    // Next-state logic; flush overrides both accept and output handshake.
    always_comb begin
        state_d      = state_q;
        page_d       = page_q;
        mask_d       = mask_q;
        pending_d    = pending_q;
        empty_drop_d = 1'b0;
        if (flush_i) begin
            state_d   = IDLE;
            pending_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        page_d    = page_i;
                        mask_d    = mask_in;
                        pending_d = pending_in;
                        if (pending_in != '0) begin
                            state_d = DISPATCH;
                        end else begin
                            empty_drop_d = 1'b1;
                        end
                    end
                end
                DISPATCH: begin
                    if (out_ready_i) begin
                        pending_d = pending_q & ~grant;
                        if (is_last) begin
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    state_d   = IDLE;
                    pending_d = '0;
                end
            endcase
        end
    end

    // State and storage registers with asynchronous reset.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            page_q       <= '0;
            mask_q       <= '0;
            pending_q    <= '0;
            empty_drop_q <= 1'b0;
            ready_en_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            page_q       <= page_d;
            mask_q       <= mask_d;
            pending_q    <= pending_d;
            empty_drop_q <= empty_drop_d;
            ready_en_q   <= 1'b1;
        end
    end

endmodule

`default_nettype wire
